// File: rtl/bcd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package : bcd_pkg                                                  |
// | Shared BCD constants and helpers for the N-digit BCD counter.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package bcd_pkg;

    localparam int         BCD_W      = 4;
    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam logic [3:0] BCD_MIN    = 4'd0;
    localparam int         MAX_DIGITS = 8;

    function automatic logic is_bcd(input logic [3:0] nibble);
        return (nibble <= BCD_MAX);
    endfunction

    // Packed all-9s terminal value, right-aligned in a MAX_DIGITS-wide word.
    function automatic logic [BCD_W*MAX_DIGITS-1:0] all_nines(input int digits);
        logic [BCD_W*MAX_DIGITS-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits) begin
                v[BCD_W*i +: BCD_W] = BCD_MAX;
            end
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : bcd_digit                                                |
// | One BCD digit with increment/decrement and carry/borrow chaining.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       up,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] d,
    input  logic       cin,
    output logic [3:0] q,
    output logic       cout
);

    logic [3:0] q_q;
    logic [3:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = BCD_MIN;
        end else if (load) begin
            q_d = d;
        end else if (en && cin) begin
            if (up) begin
                q_d = (q_q >= BCD_MAX) ? BCD_MIN : q_q + 4'd1;
            end else begin
                q_d = (q_q == BCD_MIN) ? BCD_MAX : q_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= BCD_MIN;
        end else begin
            q_q <= q_d;
        end
    end

    // cout means "this digit and all lower digits are at their rollover value".
    assign cout = cin & (up ? (q_q == BCD_MAX) : (q_q == BCD_MIN));
    assign q    = q_q;

endmodule
`default_nettype wire

// File: rtl/bcd_counter_n.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : bcd_counter_n                                            |
// | DIGITS-wide packed BCD up/down counter, wrap or saturate, cascade. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module bcd_counter_n
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 2,
    parameter bit          WRAP   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   q,
    output logic                  carry_out,
    output logic                  wrap,
    output logic                  bad_load
);

    logic [DIGITS:0]        w_carry;
    logic [4*DIGITS-1:0]    w_load_clean;
    logic [DIGITS-1:0]      w_digit_bad;
    logic                   w_at_terminal;
    logic                   w_count_en;
    logic                   wrap_q;
    logic                   wrap_d;
    logic                   bad_load_q;
    logic                   bad_load_d;

    assign w_carry[0] = 1'b1;

    generate
        for (genvar i = 0; i < int'(DIGITS); i++) begin : g_digit
            assign w_digit_bad[i]         = ~is_bcd(load_val[4*i +: 4]);
            assign w_load_clean[4*i +: 4] = w_digit_bad[i] ? BCD_MIN : load_val[4*i +: 4];

            bcd_digit u_digit (
                .clk  (clk),
                .rst  (rst),
                .en   (w_count_en),
                .up   (up),
                .clr  (clr),
                .load (load),
                .d    (w_load_clean[4*i +: 4]),
                .cin  (w_carry[i]),
                .q    (q[4*i +: 4]),
                .cout (w_carry[i+1])
            );
        end
    endgenerate

    // The ripple out of the top digit is exactly "q is all 9s (up) / all 0s (down)".
    assign w_at_terminal = w_carry[DIGITS];

    // Saturation is just suppressing the enable at terminal; wrap falls out of the ripple.
    assign w_count_en = en & ~(w_at_terminal & ~WRAP);

    assign wrap_d     = en & ~clr & ~load & w_at_terminal & WRAP;
    assign bad_load_d = ~clr & load & (|w_digit_bad);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_q     <= 1'b0;
            bad_load_q <= 1'b0;
        end else begin
            wrap_q     <= wrap_d;
            bad_load_q <= bad_load_d;
        end
    end

    assign carry_out = en & ~clr & ~load & w_at_terminal;
    assign wrap      = wrap_q;
    assign bad_load  = bad_load_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_counter_n.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_bcd_counter_n                                         |
// | Scoreboard bench: 2-digit wrapping and 3-digit saturating counters.|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_bcd_counter_n;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        en2 = 0, up2 = 1, clr2 = 0, load2 = 0;
    logic [7:0]  lv2 = '0;
    logic [7:0]  q2;
    logic        co2, wr2, bl2;

    logic        en3 = 0, up3 = 1, clr3 = 0, load3 = 0;
    logic [11:0] lv3 = '0;
    logic [11:0] q3;
    logic        co3, wr3, bl3;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        string       tag;
        int          dut;
        logic [11:0] q;
        logic        w;
        logic        b;
        logic        c;
    } exp_t;

    exp_t sb[$];

    // Expected state left by the previous edge, per DUT.
    logic [7:0]  cq2 = '0;
    logic        cw2 = 0, cb2 = 0;
    logic [11:0] cq3 = '0;
    logic        cw3 = 0, cb3 = 0;

    bcd_counter_n #(.DIGITS(2), .WRAP(1'b1)) u_dut2 (
        .clk(clk), .rst(rst), .en(en2), .up(up2), .clr(clr2), .load(load2),
        .load_val(lv2), .q(q2), .carry_out(co2), .wrap(wr2), .bad_load(bl2)
    );

    bcd_counter_n #(.DIGITS(3), .WRAP(1'b0)) u_dut3 (
        .clk(clk), .rst(rst), .en(en3), .up(up3), .clr(clr3), .load(load3),
        .load_val(lv3), .q(q3), .carry_out(co3), .wrap(wr3), .bad_load(bl3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp_v);
        end
    endtask

    function automatic logic [7:0] bcd2(input int v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'((v / 10) % 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    task automatic d2(input logic e, u, c, l, input logic [7:0] lv, input logic ec,
                      input logic [7:0] nq, input logic nw, nb, input string tag);
        exp_t x;
        en2 = e; up2 = u; clr2 = c; load2 = l; lv2 = lv;
        x.tag = tag; x.dut = 2; x.q = {4'h0, cq2}; x.w = cw2; x.b = cb2; x.c = ec;
        sb.push_back(x);
        cq2 = nq; cw2 = nw; cb2 = nb;
        @(posedge clk); #1;
    endtask

    task automatic d3(input logic e, u, c, l, input logic [11:0] lv, input logic ec,
                      input logic [11:0] nq, input logic nw, nb, input string tag);
        exp_t x;
        en3 = e; up3 = u; clr3 = c; load3 = l; lv3 = lv;
        x.tag = tag; x.dut = 3; x.q = cq3; x.w = cw3; x.b = cb3; x.c = ec;
        sb.push_back(x);
        cq3 = nq; cw3 = nw; cb3 = nb;
        @(posedge clk); #1;
    endtask

    // Monitor: mid-cycle, q/wrap/bad_load reflect the last edge and carry_out the live inputs.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.dut == 2) begin
                chk({e.tag, ".q"},     {4'h0, q2},  e.q);
                chk({e.tag, ".wrap"},  {11'h0, wr2}, {11'h0, e.w});
                chk({e.tag, ".bad"},   {11'h0, bl2}, {11'h0, e.b});
                chk({e.tag, ".carry"}, {11'h0, co2}, {11'h0, e.c});
            end else begin
                chk({e.tag, ".q"},     q3,           e.q);
                chk({e.tag, ".wrap"},  {11'h0, wr3}, {11'h0, e.w});
                chk({e.tag, ".bad"},   {11'h0, bl3}, {11'h0, e.b});
                chk({e.tag, ".carry"}, {11'h0, co3}, {11'h0, e.c});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // 100 up edges from reset: 00..99 then wrap to 00.
        for (int k = 1; k <= 100; k++) begin
            d2(1, 1, 0, 0, 8'h00, (k - 1 == 99), bcd2(k % 100), (k == 100), 0, "up_count");
        end

        // Down from 00 wraps to 99, then 98, 97.
        d2(1, 0, 0, 0, 8'h00, 1, 8'h99, 1, 0, "down_wrap");
        d2(1, 0, 0, 0, 8'h00, 0, 8'h98, 0, 0, "down_98");
        d2(1, 0, 0, 0, 8'h00, 0, 8'h97, 0, 0, "down_97");
        d2(0, 0, 0, 1, 8'h11, 0, 8'h11, 0, 0, "load_11");
        d2(1, 0, 0, 0, 8'h00, 0, 8'h10, 0, 0, "down_10");
        d2(1, 0, 0, 0, 8'h00, 0, 8'h09, 0, 0, "down_09");

        // Load sanitising.
        d2(0, 1, 0, 1, 8'h4A, 0, 8'h40, 0, 1, "load_4A");
        d2(0, 1, 0, 1, 8'h37, 0, 8'h37, 0, 0, "load_37");
        d2(0, 1, 0, 0, 8'h00, 0, 8'h37, 0, 0, "hold_37");

        // Priority clr > load > count.
        d2(0, 1, 0, 1, 8'h42, 0, 8'h42, 0, 0, "load_42");
        d2(1, 1, 1, 1, 8'h55, 0, 8'h00, 0, 0, "clr_prio");
        d2(1, 1, 0, 1, 8'h23, 0, 8'h23, 0, 0, "load_prio");
        d2(1, 1, 0, 0, 8'h00, 0, 8'h24, 0, 0, "dir_up");
        d2(1, 0, 0, 0, 8'h00, 0, 8'h23, 0, 0, "dir_down");

        // Asynchronous reset mid-cycle.
        d2(0, 1, 0, 1, 8'h56, 0, 8'h56, 0, 0, "load_56");
        d2(1, 1, 0, 0, 8'h00, 0, 8'h57, 0, 0, "up_57");
        d2(0, 1, 0, 0, 8'h00, 0, 8'h57, 0, 0, "hold_57");
        en2 = 1'b0;
        #2 rst = 1'b1;
        #1 chk("async_rst.q", {4'h0, q2}, 12'h000);
        @(posedge clk); #1;
        rst = 1'b0;
        cq2 = '0; cw2 = 0; cb2 = 0;
        d2(1, 1, 0, 0, 8'h00, 0, 8'h01, 0, 0, "first_after_rst");
        d2(0, 1, 0, 0, 8'h00, 0, 8'h01, 0, 0, "hold_01");

        // Three-digit saturating instance.
        cq3 = '0; cw3 = 0; cb3 = 0;
        d3(0, 1, 0, 1, 12'h998, 0, 12'h998, 0, 0, "sat_load");
        d3(1, 1, 0, 0, 12'h000, 0, 12'h999, 0, 0, "sat_up");
        for (int k = 0; k < 4; k++) begin
            d3(1, 1, 0, 0, 12'h000, 1, 12'h999, 0, 0, "sat_hold");
        end
        d3(0, 1, 0, 1, 12'hA5F, 0, 12'h050, 0, 1, "load_A5F");
        d3(0, 1, 0, 0, 12'h000, 0, 12'h050, 0, 0, "hold_050");
        d3(0, 1, 0, 0, 12'h000, 0, 12'h050, 0, 0, "flush");

        repeat (3) @(posedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
